// File: rtl/pdm_pkg.sv
// Shared definitions for the multi-channel PDM DAC.
//   ORDER_1 / ORDER_2 : legal loop orders
//   pdm_state_e       : modulator FSM states (IDLE, RUN)
//   sat_w / sat_hit   : clamp a wide signed sum to a W-bit signed range and
//                       report whether the clamp engaged
package pdm_pkg;

  localparam int ORDER_1  = 1;
  localparam int ORDER_2  = 2;
  localparam int SAT_MAXW = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pdm_state_e;

  function automatic logic signed [SAT_MAXW-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_MAXW-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Saturating result; callers truncate to W bits.
  function automatic logic signed [SAT_MAXW-1:0] sat_w(input logic signed [SAT_MAXW-1:0] v,
                                                       input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [SAT_MAXW-1:0] v, input int w);
    return (v > sat_max(w)) || (v < sat_min(w));
  endfunction

endpackage

// File: rtl/pdm_chan_mod.sv
// One channel of the sigma-delta loop: integrators, quantiser, sticky
// overload flag. State only moves on tick_i; clr_i zeroes everything.
//   clk, rst   : clock, async active-low reset
//   tick_i     : modulator update strobe
//   clr_i      : hold loop in its cleared state (idle / idle entry)
//   dith_i     : +1 LSB added to the first integrator sum
//   x_i        : signed sample (offset removed)
//   q_o        : registered PDM bit
//   ovf_o      : sticky saturation flag
module pdm_chan_mod
  import pdm_pkg::*;
#(
  parameter int NBITS     = 16,
  parameter int ACC_GUARD = 2,
  parameter int ORDER     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_i,
  input  logic                    clr_i,
  input  logic                    dith_i,
  input  logic signed [NBITS-1:0] x_i,
  output logic                    q_o,
  output logic                    ovf_o
);

  localparam int W    = NBITS + ACC_GUARD;
  localparam int SW   = W + 2;   // headroom so sums never wrap before clamping
  localparam int FS_I = 2 ** (NBITS - 1);
  localparam logic signed [SW-1:0] FS_P = SW'(FS_I);

  logic signed [W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
  logic signed [SW-1:0] fb, sum1, sum2;
  logic                 q, hit1, hit2;
  logic                 q_q, ovf_q;

  always_comb begin
    // quantise on the pre-update state of the last integrator
    q    = (ORDER == ORDER_2) ? ~acc2_q[W-1] : ~acc1_q[W-1];
    fb   = q ? FS_P : -FS_P;
    sum1 = SW'(acc1_q) + SW'(x_i) - fb + $signed(SW'(dith_i));
    acc1_d = W'(sat_w(SAT_MAXW'(sum1), W));
    hit1   = sat_hit(SAT_MAXW'(sum1), W);
    sum2   = '0;
    acc2_d = '0;
    hit2   = 1'b0;
    if (ORDER == ORDER_2) begin
      sum2   = SW'(acc2_q) + SW'(acc1_d) - fb;
      acc2_d = W'(sat_w(SAT_MAXW'(sum2), W));
      hit2   = sat_hit(SAT_MAXW'(sum2), W);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
      q_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clr_i) begin
      acc1_q <= '0;
      acc2_q <= '0;
      q_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (tick_i) begin
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      q_q    <= q;
      ovf_q  <= ovf_q | hit1 | hit2;
    end
  end

  assign q_o   = q_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pdm_multi.sv
// NCH-channel PDM DAC with shared update divider, IDLE/RUN control,
// one-deep pending + active sample buffering and per-channel sigma-delta
// loops of order 1 or 2.
// Optional feature macro PDM_DITHER_EN: 16-bit LFSR dither (+1 LSB on acc1).
//   clk, rst   : clock, async active-low reset
//   en         : run enable (leaving RUN waits for the next tick)
//   samp_valid : input frame valid; samp_ready : frame accepted
//   din        : NCH offset-binary samples, channel c at [c*NBITS +: NBITS]
//   dout       : PDM bitstreams
//   tick       : one-cycle modulator update strobe
//   overload   : sticky per-channel saturation flags
module pdm_multi
  import pdm_pkg::*;
#(
  parameter int NBITS      = 16,
  parameter int NCH        = 2,
  parameter int DIV_FACTOR = 3,
  parameter int ORDER      = 1,
  parameter int ACC_GUARD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  samp_valid,
  output logic                  samp_ready,
  input  logic [NCH*NBITS-1:0]  din,
  output logic [NCH-1:0]        dout,
  output logic                  tick,
  output logic [NCH-1:0]        overload
);

  if (ORDER != ORDER_1 && ORDER != ORDER_2) begin : g_bad_order
    $error("pdm_multi: ORDER must be 1 or 2");
  end

  localparam int CW = (DIV_FACTOR < 2) ? 1 : $clog2(DIV_FACTOR + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV_FACTOR);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pdm_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NCH*NBITS-1:0]  pend_q, pend_d, act_q, act_d;
  logic                  pend_full_q, pend_full_d;
  logic                  run, leave, clr, accept, dith;

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---- FSM: next state (RUN only exits on a tick)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (tick && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    run        = (state_q == RUN);
    tick       = run && (cnt_q == CNT_TOP);
    samp_ready = run && (!pend_full_q || tick);
    leave      = tick && !en;
    clr        = !run || leave;
  end

  assign accept = samp_valid && samp_ready;

  // ---- divider
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (!run || tick) cnt_d = CNT_ONE;
  end

  // ---- buffers: on a tick the pending frame (or, with pending empty, a
  // frame accepted in the same cycle) becomes active; otherwise active repeats.
  always_comb begin
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (tick) begin
      if (pend_full_q)  act_d = pend_q;
      else if (accept)  act_d = din;
    end
    if (leave) begin
      pend_full_d = 1'b0;
    end else if (accept && !(tick && !pend_full_q)) begin
      pend_d      = din;
      pend_full_d = 1'b1;
    end else if (tick) begin
      pend_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= CNT_ONE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
    end
  end

`ifdef PDM_DITHER_EN
  logic [15:0] lfsr_q;
  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      lfsr_q <= 16'hACE1;
    else if (tick) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign dith = lfsr_q[0];
`else
  assign dith = 1'b0;
`endif

  // ---- channels: the loop sees the frame that becomes active at this tick
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [NBITS-1:0] x;
    assign x = $signed({~act_d[g*NBITS+NBITS-1], act_d[g*NBITS +: NBITS-1]});

    pdm_chan_mod #(
      .NBITS    (NBITS),
      .ACC_GUARD(ACC_GUARD),
      .ORDER    (ORDER)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick_i(tick),
      .clr_i (clr),
      .dith_i(dith),
      .x_i   (x),
      .q_o   (dout[g]),
      .ovf_o (overload[g])
    );
  end

endmodule
